// File: rtl/boid_pixel_writer.sv
// Renders boid position updates: erases the previous pixel(s), then draws the current one(s).
// Define BOID_PIXEL_WRITER_BOX_EN to render a 2x2 box per position instead of a single pixel.
module boid_pixel_writer #(
    parameter int                 SCREEN_W    = 640,
    parameter int                 SCREEN_H    = 480,
    parameter int                 ADDR_W      = 19,
    parameter int                 COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] DRAW_COLOR  = 8'hFF,
    parameter logic [COLOR_W-1:0] ERASE_COLOR = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        x,
    input  logic [31:0]        y,
    input  logic [31:0]        px,
    input  logic [31:0]        py,
    output logic               fb_we,
    input  logic               fb_ready,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

    localparam logic signed [16:0] COL_LIM = 17'(SCREEN_W);
    localparam logic signed [16:0] ROW_LIM = 17'(SCREEN_H);

    state_t             state_reg, state_next;
    logic signed [15:0] x_reg, y_reg, px_reg, py_reg;
    logic signed [15:0] base_col, base_row;
    logic signed [16:0] col, row;
    logic [ADDR_W-1:0]  pix_addr;
    logic               capture, advance, last_pix, dx, dy, clipped;
    logic               unused_frac;

    // Fractions are truncated, so only the integer halves are kept.
    assign unused_frac = ^{x[15:0], y[15:0], px[15:0], py[15:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            px_reg    <= '0;
            py_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                x_reg  <= x[31:16];
                y_reg  <= y[31:16];
                px_reg <= px[31:16];
                py_reg <= py[31:16];
            end
        end
    end

`ifdef BOID_PIXEL_WRITER_BOX_EN
    logic [1:0] pix_cnt_reg;

    // Wraps 3 -> 0 on the last pixel, so each phase starts at (c,r).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_cnt_reg <= '0;
        else if (advance)
            pix_cnt_reg <= pix_cnt_reg + 2'd1;
    end

    assign last_pix = &pix_cnt_reg;
    assign dx       = pix_cnt_reg[0];
    assign dy       = pix_cnt_reg[1];
`else
    logic unused_advance;

    assign unused_advance = advance;
    assign last_pix       = 1'b1;
    assign dx             = 1'b0;
    assign dy             = 1'b0;
`endif

    assign base_col = (state_reg == DRAW) ? x_reg : px_reg;
    assign base_row = (state_reg == DRAW) ? y_reg : py_reg;

    // One extra bit so col+1 / row+1 at the top of the 16-bit range cannot wrap.
    assign col = {base_col[15], base_col} + {16'd0, dx};
    assign row = {base_row[15], base_row} + {16'd0, dy};

    assign clipped  = col[16] || row[16] || (col >= COL_LIM) || (row >= ROW_LIM);
    assign pix_addr = ADDR_W'(row) * ADDR_W'(SCREEN_W) + ADDR_W'(col);

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_data    = '0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    state_next = ERASE;
                end
            end
            ERASE, DRAW: begin
                fb_we = !clipped;
                if (!clipped) begin
                    fb_addr = pix_addr;
                    fb_data = (state_reg == DRAW) ? DRAW_COLOR : ERASE_COLOR;
                end
                // A clipped pixel still costs its cycle but never waits on the arbiter.
                advance = clipped || fb_ready;
                if (advance && last_pix) begin
                    if (state_reg == ERASE) begin
                        state_next = DRAW;
                    end else begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Directed bench for boid_pixel_writer; box-mode vectors replace the single-pixel ones
// when BOID_PIXEL_WRITER_BOX_EN is defined.
module tb_boid_pixel_writer;

    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 8;

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        x = '0, y = '0, px = '0, py = '0;
    logic               fb_we;
    logic               fb_ready = 1'b1;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cap_q[$];
    int wr_cyc[$];
    int wr_addr[$];
    int wr_data[$];
    int done_q[$];

    always #5 clk = ~clk;

    boid_pixel_writer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .px       (px),
        .py       (py),
        .fb_we    (fb_we),
        .fb_ready (fb_ready),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .done     (done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready && !reset)
            cap_q.push_back(cyc + 1);
    end

    always @(negedge clk) begin
        if (fb_we && fb_ready) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_data));
            $display("write  cyc=%0d addr=%0d data=%02h", cyc, fb_addr, fb_data);
        end
        if (done)
            done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_q.delete();
    endtask

    // Waits (bounded) for a capture beyond n0; t is the capture edge, -1 on timeout.
    task automatic wait_cap(input int n0, output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (cap_q.size() > n0) break;
        end
        if (cap_q.size() > n0) t = cap_q[$];
        else chk("capture_timeout", 0, 1);
    endtask

    // Returns in the first cycle after the capture edge (relative cycle 1).
    task automatic send(input logic [31:0] nx, input logic [31:0] ny,
                        input logic [31:0] npx, input logic [31:0] npy,
                        input logic rdy, output int t);
        int n0;
        clear_logs();
        n0 = cap_q.size();
        @(posedge clk); #1;
        x = nx; y = ny; px = npx; py = npy;
        fb_ready = rdy;
        in_valid = 1'b1;
        wait_cap(n0, t);
        in_valid = 1'b0;
        $display("update x=%08h y=%08h px=%08h py=%08h captured at %0d", nx, ny, npx, npy, t);
    endtask

    task automatic check_wr(input string tag, input int i, input int t,
                            input int rel, input int addr, input int data);
        if (i >= wr_addr.size()) begin
            chk({tag, "_present"}, wr_addr.size(), i + 1);
            return;
        end
        chk({tag, "_cycle"}, wr_cyc[i] - t + 1, rel);
        chk({tag, "_addr"}, wr_addr[i], addr);
        chk({tag, "_data"}, wr_data[i], data);
    endtask

    task automatic finish_update(input string tag, input int t, input int n_wr, input int done_rel);
        repeat (14) @(posedge clk);
        #1;
        chk({tag, "_nwrites"}, wr_addr.size(), n_wr);
        chk({tag, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0)
            chk({tag, "_done_cycle"}, done_q[0] - t + 1, done_rel);
    endtask

    initial begin
        int t, t2, n0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

`ifdef BOID_PIXEL_WRITER_BOX_EN
        send(639 << 16, 479 << 16, 100 << 16, 100 << 16, 1'b1, t);
        finish_update("box", t, 5, 8);
        check_wr("box_e0", 0, t, 1, 64100, 8'h00);
        check_wr("box_e1", 1, t, 2, 64101, 8'h00);
        check_wr("box_e2", 2, t, 3, 64740, 8'h00);
        check_wr("box_e3", 3, t, 4, 64741, 8'h00);
        check_wr("box_d0", 4, t, 5, 307199, 8'hFF);
`else
        // Basic update
        send(10 << 16, 20 << 16, 9 << 16, 19 << 16, 1'b1, t);
        chk("basic_busy", in_ready, 0);
        finish_update("basic", t, 2, 2);
        check_wr("basic_erase", 0, t, 1, 12169, 8'h00);
        check_wr("basic_draw", 1, t, 2, 12810, 8'hFF);

        // Draw clipped on the left
        send(32'hFFFF0000, 5 << 16, 0, 0, 1'b1, t);
        finish_update("clip_left", t, 1, 2);
        check_wr("clip_left_erase", 0, t, 1, 0, 8'h00);

        // Draw clipped on the right
        send(640 << 16, 5 << 16, 3 << 16, 2 << 16, 1'b1, t);
        finish_update("clip_right", t, 1, 2);
        check_wr("clip_right_erase", 0, t, 1, 1283, 8'h00);

        // Draw clipped at the bottom, erase at col -1 from a negative fraction
        send(5 << 16, 480 << 16, 32'hFFFF8000, 7 << 16, 1'b1, t);
        finish_update("clip_both", t, 0, 2);

        // Fractions truncate; corner coordinates stay in range
        send((10 << 16) | 32'h0000FFFF, (479 << 16) | 32'h00008000, 639 << 16, 0, 1'b1, t);
        finish_update("frac", t, 2, 2);
        check_wr("frac_erase", 0, t, 1, 639, 8'h00);
        check_wr("frac_draw", 1, t, 2, 306570, 8'hFF);

        // Backpressure: three stalled cycles during erase
        send(10 << 16, 20 << 16, 9 << 16, 19 << 16, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_we", fb_we, 1);
            chk("bp_hold_addr", int'(fb_addr), 12169);
            chk("bp_hold_data", int'(fb_data), 0);
            @(posedge clk); #1;
        end
        fb_ready = 1'b1;
        finish_update("bp", t, 2, 5);
        check_wr("bp_erase", 0, t, 4, 12169, 8'h00);
        check_wr("bp_draw", 1, t, 5, 12810, 8'hFF);

        // Reset while an erase is stalled
        send(1 << 16, 1 << 16, 2 << 16, 2 << 16, 1'b0, t);
        chk("rstmid_we_before", fb_we, 1);
        chk("rstmid_addr_before", int'(fb_addr), 1282);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_we_async", fb_we, 0);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_addr", int'(fb_addr), 0);
        @(posedge clk); #1;
        reset    = 1'b0;
        fb_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid_no_writes", wr_addr.size(), 0);
        chk("rstmid_no_done", done_q.size(), 0);
        $display("reset mid-update checked");

        // Back-to-back with in_valid held high
        clear_logs();
        n0 = cap_q.size();
        @(posedge clk); #1;
        x = 30 << 16; y = 40 << 16; px = 29 << 16; py = 39 << 16;
        in_valid = 1'b1;
        wait_cap(n0, t);
        x = 100 << 16; y = 0; px = 0; py = 479 << 16;
        wait_cap(n0 + 1, t2);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("back-to-back captures at %0d and %0d", t, t2);
        chk("b2b_gap", t2 - t, 3);
        chk("b2b_nwrites", wr_addr.size(), 4);
        check_wr("b2b_a_erase", 0, t, 1, 24989, 8'h00);
        check_wr("b2b_a_draw", 1, t, 2, 25630, 8'hFF);
        check_wr("b2b_b_erase", 2, t, 4, 306560, 8'h00);
        check_wr("b2b_b_draw", 3, t, 5, 100, 8'hFF);
        chk("b2b_ndone", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b_done_a", done_q[0] - t + 1, 2);
            chk("b2b_done_b", done_q[1] - t + 1, 5);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
